// File: rtl/fir_deci_axis.sv
// fir_deci_axis: streaming decimating direct-form FIR filter.
// Ports: s_axis_* signed sample input (valid/ready), m_axis_* filtered
//        output, one sample per DECI accepted inputs; active-low async reset.
module fir_deci_axis #(
    parameter int  DW          = 24,
    parameter int  TAPS        = 8,
    parameter real COEF [TAPS] = '{default: 0.124},
    parameter int  DECI        = 2
) (
    input  logic          s_axis_aclk,
    input  logic          s_axis_aresetn,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [DW-1:0] m_axis_tdata
);

    localparam int  PW   = 2 * DW;
    localparam int  AW   = PW + $clog2(TAPS);
    localparam int  CW   = (DECI > 1) ? $clog2(DECI) : 1;
    localparam real QS   = 2.0 ** (DW - 1);
    localparam real QMAX = QS - 1.0;

    // Q1.(DW-1) coefficients, clamped then rounded half away from zero.
    logic signed [DW-1:0] cq [TAPS];

    for (genvar k = 0; k < TAPS; k++) begin : g_cq
        localparam real RS = COEF[k] * QS;
        localparam real RC = (RS > QMAX) ? QMAX : ((RS < -QS) ? -QS : RS);
        localparam longint RI = (RC >= 0.0) ? longint'($rtoi(RC + 0.5))
                                            : -longint'($rtoi(0.5 - RC));
        assign cq[k] = RI[DW-1:0];
    end

    logic signed [DW-1:0] din;
    logic signed [DW-1:0] dl_q [TAPS-1];
    logic signed [DW-1:0] dl_d [TAPS-1];
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 run_q;
    logic                 run_d;
    logic                 vld_q;
    logic                 vld_d;
    logic [DW-1:0]        dat_q;
    logic [DW-1:0]        dat_d;
    logic                 s_en;
    logic                 m_en;
    logic                 co;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sh;
    logic [DW-1:0]        y_sat;

    function automatic logic signed [AW-1:0] mul_ext(
        logic signed [DW-1:0] a,
        logic signed [DW-1:0] b
    );
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        logic signed [PW-1:0] p;
        ax = {{DW{a[DW-1]}}, a};
        bx = {{DW{b[DW-1]}}, b};
        p  = ax * bx;
        return {{(AW-PW){p[PW-1]}}, p};
    endfunction

    assign din           = s_axis_tdata;
    // Ready only when the output register is free or drains this cycle,
    // so a pending result can never be overwritten.
    assign s_axis_tready = run_q & (~vld_q | m_axis_tready);
    assign s_en          = s_axis_tvalid & s_axis_tready;
    assign m_en          = vld_q & m_axis_tready;
    assign co            = s_en & (cnt_q == CW'(DECI - 1));

    // Full-precision sum; the newest sample comes straight from the input.
    always_comb begin
        acc = mul_ext(cq[0], din);
        for (int k = 1; k < TAPS; k++) begin
            acc = acc + mul_ext(cq[k], dl_q[k-1]);
        end
    end

    assign acc_sh = acc >>> (DW - 1);

    // Saturate when the bits above the output sign are not a sign copy.
    always_comb begin
        y_sat = acc_sh[DW-1:0];
        if (acc_sh[AW-1:DW-1] != {(AW-DW+1){acc_sh[AW-1]}}) begin
            y_sat = acc_sh[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                 : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_comb begin
        dl_d  = dl_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        dat_d = dat_q;
        run_d = 1'b1;
        if (s_en) begin
            dl_d[0] = din;
            for (int k = 1; k < TAPS - 1; k++) begin
                dl_d[k] = dl_q[k-1];
            end
            cnt_d = co ? '0 : cnt_q + 1'b1;
        end
        if (co) begin
            vld_d = 1'b1;
            dat_d = y_sat;
        end else if (m_en) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                dl_q[k] <= '0;
            end
            cnt_q <= '0;
            run_q <= 1'b0;
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            dl_q  <= dl_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = dat_q;

endmodule

// File: tb/tb_fir_deci_axis.sv
// tb_fir_deci_axis: four filter configurations driven by one shared stream,
// each checked every cycle against a sample-history reference model.
module tb_fir_deci_axis;

    localparam int  DW = 24;
    localparam real IMP [4] = '{0.5, 0.25, -0.25, 0.125};
    localparam real HLF [4] = '{0.5, 0.5, 0.5, 0.5};
    localparam real LP [13] = '{-0.01, -0.02, 0.0, 0.06, 0.15, 0.23, 0.27,
                                0.23, 0.15, 0.06, 0.0, -0.02, -0.01};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_vld = 1'b0;
    logic          m_rdy = 1'b1;
    logic [DW-1:0] s_dat = '0;
    logic          s_rdy [4];
    logic          m_vld [4];
    logic [DW-1:0] m_dat [4];

    always #5 clk = ~clk;

    fir_deci_axis #(.DW(DW), .TAPS(4), .COEF(IMP), .DECI(1)) u_imp1 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy[0]),
        .s_axis_tdata(s_dat), .m_axis_tvalid(m_vld[0]),
        .m_axis_tready(m_rdy), .m_axis_tdata(m_dat[0]));

    fir_deci_axis #(.DW(DW), .TAPS(4), .COEF(IMP), .DECI(2)) u_imp2 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy[1]),
        .s_axis_tdata(s_dat), .m_axis_tvalid(m_vld[1]),
        .m_axis_tready(m_rdy), .m_axis_tdata(m_dat[1]));

    fir_deci_axis #(.DW(DW), .TAPS(4), .COEF(HLF), .DECI(1)) u_sat (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy[2]),
        .s_axis_tdata(s_dat), .m_axis_tvalid(m_vld[2]),
        .m_axis_tready(m_rdy), .m_axis_tdata(m_dat[2]));

    fir_deci_axis #(.DW(DW), .TAPS(13), .COEF(LP), .DECI(2)) u_lp (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy[3]),
        .s_axis_tdata(s_dat), .m_axis_tvalid(m_vld[3]),
        .m_axis_tready(m_rdy), .m_axis_tdata(m_dat[3]));

    int total = 0;
    int bad   = 0;

    // Reference model: quantized taps, history of accepted samples.
    longint cq_m [4][13];
    int     nt   [4] = '{4, 4, 4, 13};
    int     dc   [4] = '{1, 2, 1, 2};
    longint hist [4][16];
    int     nacc [4];
    bit     mv   [4];
    longint md   [4];
    bit     run_m;

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    int  acc3 = 0;
    int  out3 = 0;
    bit  last_acc3 = 1'b0;

    function automatic longint quant(real c);
        real r;
        r = $floor(c * 8388608.0 + 0.5);
        if (r > 8388607.0) r = 8388607.0;
        if (r < -8388608.0) r = -8388608.0;
        return longint'(r);
    endfunction

    function automatic longint scale_sat(longint a);
        longint s;
        s = a >>> 23;
        if (s > 64'sd8388607) s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return s;
    endfunction

    function automatic logic [DW-1:0] dds(logic [31:0] ph);
        real    a;
        longint v;
        logic [DW-1:0] r;
        a = 6.283185307179586 * real'(ph) / 4294967296.0;
        v = longint'($floor($cos(a) * 8388607.0 + 0.5));
        r = v[DW-1:0];
        return r;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) hist[i][k] = 0;
            nacc[i] = 0;
            mv[i]   = 1'b0;
            md[i]   = 0;
        end
        run_m = 1'b0;
    endtask

    task automatic mdl_update(int i, bit sen, longint x, bit mr);
        longint y;
        bit     emit;
        emit = 1'b0;
        if (sen) begin
            y = cq_m[i][0] * x;
            for (int k = 1; k < nt[i]; k++) y += cq_m[i][k] * hist[i][k-1];
            for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = x;
            nacc[i]++;
            if (nacc[i] % dc[i] == 0) begin
                emit  = 1'b1;
                mv[i] = 1'b1;
                md[i] = scale_sat(y);
            end
        end
        if (!emit && mv[i] && mr) mv[i] = 1'b0;
    endtask

    task automatic chk(string nm, int i, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] e;
        for (int i = 0; i < 4; i++) begin
            e = md[i][DW-1:0];
            chk("s_tready", i, longint'(s_rdy[i]),
                longint'(run_m & (~mv[i] | m_rdy)));
            chk("m_tvalid", i, longint'(m_vld[i]), longint'(mv[i]));
            chk("m_tdata", i, longint'(m_dat[i]), longint'(e));
        end
    endtask

    // One clock: settle, compare, then advance the model across the edge.
    task automatic step();
        bit     sv;
        bit     mr;
        bit     sen [4];
        longint x;
        #1;
        check_all();
        sv = s_vld;
        mr = m_rdy;
        x  = longint'($signed(s_dat));
        for (int i = 0; i < 4; i++) sen[i] = sv & run_m & (~mv[i] | mr);
        if (m_vld[0] && mr) q0.push_back(m_dat[0]);
        if (m_vld[1] && mr) q1.push_back(m_dat[1]);
        if (m_vld[2] && mr) q2.push_back(m_dat[2]);
        if (sen[3]) acc3++;
        if (m_vld[3] && mr) out3++;
        last_acc3 = sen[3];
        @(posedge clk);
        if (!rst_n) begin
            mdl_reset();
        end else begin
            for (int i = 0; i < 4; i++) mdl_update(i, sen[i], x, mr);
            run_m = 1'b1;
        end
        #2;
    endtask

    function automatic longint qget(logic [DW-1:0] q [$], int j);
        if (j < q.size()) return longint'(q[j]);
        return -1;
    endfunction

    logic [DW-1:0] imp1_e [5] = '{24'h200000, 24'h100000, 24'hF00000,
                                  24'h080000, 24'h000000};
    logic [DW-1:0] imp2_e [4] = '{24'h100000, 24'h080000, 24'h000000,
                                  24'h000000};
    logic [31:0]   phase;

    initial begin
        for (int k = 0; k < 4; k++) begin
            cq_m[0][k] = quant(IMP[k]);
            cq_m[1][k] = quant(IMP[k]);
            cq_m[2][k] = quant(HLF[k]);
        end
        for (int k = 0; k < 13; k++) cq_m[3][k] = quant(LP[k]);
        mdl_reset();

        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            chk("rst_vld", i, longint'(m_vld[i]), 0);
            chk("rst_dat", i, longint'(m_dat[i]), 0);
            chk("rst_rdy", i, longint'(s_rdy[i]), 0);
        end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        #1;
        chk("rdy_after_rel", 0, longint'(s_rdy[0]), 1);

        // Impulse through both DECI=1 and DECI=2 filters.
        q0.delete();
        q1.delete();
        s_vld = 1'b1;
        s_dat = 24'h400000;
        step();
        s_dat = '0;
        repeat (7) step();
        s_vld = 1'b0;
        repeat (3) step();
        for (int j = 0; j < 5; j++) chk("imp_d1", j, qget(q0, j), longint'(imp1_e[j]));
        chk("imp_d2_cnt", 1, longint'(q1.size()), 4);
        for (int j = 0; j < 4; j++) chk("imp_d2", j, qget(q1, j), longint'(imp2_e[j]));

        // Positive then negative full-scale saturation.
        q2.delete();
        s_vld = 1'b1;
        s_dat = 24'h7FFFFF;
        repeat (6) step();
        s_vld = 1'b0;
        repeat (2) step();
        chk("sat_pos", 2, qget(q2, q2.size() - 1), longint'(24'h7FFFFF));
        q2.delete();
        s_vld = 1'b1;
        s_dat = 24'h800000;
        repeat (6) step();
        s_vld = 1'b0;
        repeat (2) step();
        chk("sat_neg", 2, qget(q2, q2.size() - 1), longint'(24'h800000));

        // Backpressure: output held, input stalled, same-cycle resume.
        m_rdy = 1'b0;
        s_vld = 1'b1;
        s_dat = 24'h123456;
        repeat (12) step();
        #1;
        chk("bp_rdy", 0, longint'(s_rdy[0]), 0);
        chk("bp_vld", 0, longint'(m_vld[0]), 1);
        m_rdy = 1'b1;
        #1;
        chk("bp_resume", 0, longint'(s_rdy[0]), 1);
        s_vld = 1'b0;
        repeat (2) step();

        // Asynchronous reset in the middle of traffic with output pending.
        s_vld = 1'b1;
        for (int j = 0; j < 5; j++) begin
            s_dat = DW'($urandom);
            step();
        end
        m_rdy = 1'b0;
        step();
        rst_n = 1'b0;
        mdl_reset();
        acc3 = 0;
        out3 = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("arst_vld", i, longint'(m_vld[i]), 0);
            chk("arst_dat", i, longint'(m_dat[i]), 0);
            chk("arst_rdy", i, longint'(s_rdy[i]), 0);
        end
        s_vld = 1'b0;
        m_rdy = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        q0.delete();
        q1.delete();
        s_vld = 1'b1;
        s_dat = 24'h400000;
        step();
        s_dat = '0;
        repeat (3) step();
        s_vld = 1'b0;
        repeat (2) step();
        chk("fresh_d1", 0, qget(q0, 0), longint'(24'h200000));
        chk("fresh_d2", 1, qget(q1, 0), longint'(24'h100000));

        // Random-valid DDS cosine stream, later with random backpressure.
        phase = '0;
        for (int j = 0; j < 800; j++) begin
            s_vld = 1'($urandom_range(0, 1));
            m_rdy = (j < 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_dat = dds(phase);
            step();
            if (last_acc3) phase = phase + 32'd858993459;
        end
        s_vld = 1'b0;
        m_rdy = 1'b1;
        repeat (4) step();
        chk("out_count", 3, longint'(out3), longint'(acc3 / 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
